// File: rtl/issue_select_if.sv
// Bundles the scheduler select-stage signals: wakeup requests, dispatch allocation and FU readiness in; grants and frees out.
// The master side drives requests, allocation, readiness and flush, and receives the grants.
// The slave side is the select stage itself.
interface issue_select_if #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = 4,
  parameter int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  parameter int FU_W     = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1
);
  logic [NUM_ROWS-1:0]       request_vector;
  logic                      alloc_en;
  logic [ROW_W-1:0]          alloc_row;
  logic [FU_W-1:0]           alloc_fu;
  logic [NUM_FUS-1:0]        fu_ready;
  logic                      flush;
  logic [NUM_FUS-1:0]        grant_valid;
  logic [NUM_FUS*ROW_W-1:0]  grant_row;
  logic [NUM_ROWS-1:0]       select_vector;

  modport master (
    output request_vector, alloc_en, alloc_row, alloc_fu, fu_ready, flush,
    input  grant_valid, grant_row, select_vector
  );

  modport slave (
    input  request_vector, alloc_en, alloc_row, alloc_fu, fu_ready, flush,
    output grant_valid, grant_row, select_vector
  );
endinterface

// File: rtl/issue_select.sv
// Issue select: picks at most one row per FU each cycle, round-robin per FU, and masks rows that were already issued.
// Latency: a request that is eligible in cycle N is granted, and freed to wakeup, from flops in cycle N+1.
// Backpressure: a low fu_ready[f] blocks that FU's grant and freezes its round-robin pointer; the other FUs are unaffected.
module issue_select #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = 4,
  parameter int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  parameter int FU_W     = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  issue_select_if.slave  bus
);

  // Per-row target FU, and the sticky issued mask that blocks a second grant before wakeup drops the request.
  logic [FU_W-1:0]           fu_table_q [NUM_ROWS];
  logic [NUM_ROWS-1:0]       issued_q;
  logic [NUM_ROWS-1:0]       issued_d;

  // Per-FU round-robin start point: the row after the last one granted.
  logic [ROW_W-1:0]          rr_ptr_q [NUM_FUS];
  logic [ROW_W-1:0]          rr_ptr_d [NUM_FUS];

  // Registered outputs
  logic [NUM_FUS-1:0]        grant_valid_q;
  logic [NUM_FUS-1:0]        grant_valid_d;
  logic [NUM_FUS*ROW_W-1:0]  grant_row_q;
  logic [NUM_FUS*ROW_W-1:0]  grant_row_d;
  logic [NUM_ROWS-1:0]       select_q;
  logic [NUM_ROWS-1:0]       select_d;

  // Eligibility matrix, one row mask per FU
  logic [NUM_ROWS-1:0]       elig [NUM_FUS];

  // Build per-FU eligible masks; a row being re-allocated this cycle is never granted on its stale request.
  always_comb begin
    for (int f = 0; f < NUM_FUS; f++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        elig[f][r] = bus.request_vector[r]
                  && !issued_q[r]
                  && (fu_table_q[r] == FU_W'(f))
                  && !(bus.alloc_en && (bus.alloc_row == ROW_W'(r)))
                  && bus.fu_ready[f]
                  && !bus.flush;
      end
    end
  end

  // Round-robin pick per FU: first eligible row at or above the pointer, wrapping at the last row.
  always_comb begin : pick_c
    int               idx;
    logic             found;
    logic [ROW_W-1:0] idx_w;
    idx           = 0;
    found         = 1'b0;
    idx_w         = '0;
    grant_valid_d = '0;
    grant_row_d   = '0;
    select_d      = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      rr_ptr_d[f] = rr_ptr_q[f];
    end
    for (int f = 0; f < NUM_FUS; f++) begin
      found = 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        idx = int'(rr_ptr_q[f]) + i;
        if (idx >= NUM_ROWS) begin
          idx = idx - NUM_ROWS;
        end
        idx_w = ROW_W'(idx);
        if (!found && elig[f][idx_w]) begin
          found                         = 1'b1;
          grant_valid_d[f]              = 1'b1;
          grant_row_d[f*ROW_W +: ROW_W] = idx_w;
          select_d[idx_w]               = 1'b1;
          rr_ptr_d[f]                   = (idx == NUM_ROWS - 1) ? '0 : ROW_W'(idx + 1);
        end
      end
    end
  end

  // Issued-mask next state: flush wipes it, grants set bits, and allocation clears the new row (allocation is applied last so it survives a flush).
  always_comb begin
    issued_d = bus.flush ? '0 : (issued_q | select_d);
    if (bus.alloc_en) begin
      issued_d[bus.alloc_row] = 1'b0;
    end
  end

  // State and output registers; the asynchronous reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_valid_q <= '0;
      grant_row_q   <= '0;
      select_q      <= '0;
      issued_q      <= '0;
      for (int f = 0; f < NUM_FUS; f++) begin
        rr_ptr_q[f] <= '0;
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        fu_table_q[r] <= '0;
      end
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_row_q   <= grant_row_d;
      select_q      <= select_d;
      issued_q      <= issued_d;
      for (int f = 0; f < NUM_FUS; f++) begin
        rr_ptr_q[f] <= rr_ptr_d[f];
      end
      if (bus.alloc_en) begin
        fu_table_q[bus.alloc_row] <= bus.alloc_fu;
      end
    end
  end

  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_row     = grant_row_q;
  assign bus.select_vector = select_q;

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: directed scenarios followed by random traffic.
// Expected grants come from a row/pointer model and are queued; a monitor compares them one cycle later.
// Async reset is exercised between clock edges.
module tb_issue_select;
  localparam int NR = 8;
  localparam int NF = 4;
  localparam int RW = 3;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  issue_select_if #(.NUM_ROWS(NR), .NUM_FUS(NF)) bus();

  issue_select #(.NUM_ROWS(NR), .NUM_FUS(NF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NF-1:0]    gv;
    logic [NF*RW-1:0] gr;
    logic [NR-1:0]    sel;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  // Reference state: target FU per row, issued flag per row, next start row per FU
  int m_fu  [NR];
  bit m_iss [NR];
  int m_ptr [NF];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_fu[r]  = 0;
      m_iss[r] = 1'b0;
    end
    for (int f = 0; f < NF; f++) m_ptr[f] = 0;
  endtask

  task automatic drive_idle();
    bus.request_vector = '0;
    bus.alloc_en       = 1'b0;
    bus.alloc_row      = '0;
    bus.alloc_fu       = '0;
    bus.fu_ready       = '0;
    bus.flush          = 1'b0;
  endtask

  // Drive one cycle of inputs and queue the response expected at the next rising edge.
  task automatic step(input logic [NR-1:0] req, input bit ae, input int ar, input int af,
                      input logic [NF-1:0] rdy, input bit fl);
    exp_t e;
    int   cand[$];
    int   pick;
    @(negedge clk);
    bus.request_vector = req;
    bus.alloc_en       = ae;
    bus.alloc_row      = RW'(ar);
    bus.alloc_fu       = FW'(af);
    bus.fu_ready       = rdy;
    bus.flush          = fl;
    e.gv  = '0;
    e.gr  = '0;
    e.sel = '0;
    for (int f = 0; f < NF; f++) begin
      cand.delete();
      if (rdy[f] && !fl) begin
        for (int r = 0; r < NR; r++)
          if (req[r] && !m_iss[r] && m_fu[r] == f && !(ae && ar == r)) cand.push_back(r);
      end
      if (cand.size() > 0) begin
        // Lowest candidate at or above the pointer; otherwise wrap to the lowest candidate overall.
        pick = -1;
        foreach (cand[k])
          if (cand[k] >= m_ptr[f] && (pick < 0 || cand[k] < pick)) pick = cand[k];
        if (pick < 0) pick = cand[0];
        e.gv[f]            = 1'b1;
        e.gr[f*RW +: RW]   = RW'(pick);
        e.sel[pick]        = 1'b1;
        m_ptr[f]           = (pick + 1) % NR;
      end
    end
    if (fl) begin
      for (int r = 0; r < NR; r++) m_iss[r] = 1'b0;
    end else begin
      for (int r = 0; r < NR; r++) if (e.sel[r]) m_iss[r] = 1'b1;
    end
    if (ae) begin
      m_fu[ar]  = af;
      m_iss[ar] = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Directed check of the outputs registered at the next rising edge.
  task automatic dchk(input string nm, input logic [NF-1:0] gv, input logic [NF*RW-1:0] gr,
                      input logic [NR-1:0] sel);
    @(posedge clk);
    #2;
    check({nm, "_gv"},  32'(bus.grant_valid),   32'(gv));
    check({nm, "_gr"},  32'(bus.grant_row),     32'(gr));
    check({nm, "_sel"}, 32'(bus.select_vector), 32'(sel));
  endtask

  // Scoreboard monitor: one expected entry per rising edge while the scoreboard is armed.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && sb.size() > 0) begin
      e = sb.pop_front();
      check("mon_grant_valid",   32'(bus.grant_valid),   32'(e.gv));
      check("mon_grant_row",     32'(bus.grant_row),     32'(e.gr));
      check("mon_select_vector", 32'(bus.select_vector), 32'(e.sel));
    end
  end

  initial begin
    drive_idle();
    model_reset();
    rst = 1'b0;
    #12;
    check("rst_gv",  32'(bus.grant_valid),   32'h0);
    check("rst_gr",  32'(bus.grant_row),     32'h0);
    check("rst_sel", 32'(bus.select_vector), 32'h0);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Basic grant: row 3 on FU1, then a single-cycle grant despite a held request
    step(8'h00, 1'b1, 3, 1, 4'hF, 1'b0);
    step(8'h08, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("basic", 4'b0010, 12'h018, 8'h08);
    step(8'h08, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("basic_once", 4'b0000, 12'h000, 8'h00);

    // Round-robin on FU0 across rows 1, 4, 6, then wrap 7 -> 0 -> 1 after reallocating row 1
    step(8'h00, 1'b1, 1, 0, 4'hF, 1'b0);
    step(8'h00, 1'b1, 4, 0, 4'hF, 1'b0);
    step(8'h00, 1'b1, 6, 0, 4'hF, 1'b0);
    step(8'h52, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("rr_1", 4'b0001, 12'h001, 8'h02);
    step(8'h52, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("rr_4", 4'b0001, 12'h004, 8'h10);
    step(8'h52, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("rr_6", 4'b0001, 12'h006, 8'h40);
    step(8'h52, 1'b1, 1, 0, 4'hF, 1'b0);
    dchk("rr_realloc", 4'b0000, 12'h000, 8'h00);
    step(8'h02, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("rr_wrap", 4'b0001, 12'h001, 8'h02);

    // Parallel FUs: rows 0/2/5/7 on FU0..FU3 all granted together
    step(8'h00, 1'b1, 0, 0, 4'hF, 1'b0);
    step(8'h00, 1'b1, 2, 1, 4'hF, 1'b0);
    step(8'h00, 1'b1, 5, 2, 4'hF, 1'b0);
    step(8'h00, 1'b1, 7, 3, 4'hF, 1'b0);
    step(8'hA5, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("par", 4'hF, 12'hF50, 8'hA5);

    // Backpressure on FU2, then release
    step(8'h00, 1'b1, 5, 2, 4'hF, 1'b0);
    step(8'h20, 1'b0, 0, 0, 4'hB, 1'b0);
    dchk("bp_hold", 4'b0000, 12'h000, 8'h00);
    step(8'h20, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("bp_go", 4'b0100, 12'h140, 8'h20);

    // Allocation colliding with a request for the same row
    step(8'h10, 1'b1, 4, 0, 4'hF, 1'b0);
    dchk("coll_block", 4'b0000, 12'h000, 8'h00);
    step(8'h10, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("coll_next", 4'b0001, 12'h004, 8'h10);

    // Flush kills the selection and clears issued, so row 4 is granted again
    step(8'h10, 1'b0, 0, 0, 4'hF, 1'b1);
    dchk("flush_kill", 4'b0000, 12'h000, 8'h00);
    step(8'h10, 1'b0, 0, 0, 4'hF, 1'b0);
    dchk("flush_regrant", 4'b0001, 12'h004, 8'h10);

    // Async reset between edges while a grant is showing
    step(8'h00, 1'b0, 0, 0, 4'hF, 1'b1);
    step(8'h10, 1'b0, 0, 0, 4'hF, 1'b0);
    @(posedge clk);
    #2;
    check("areset_pre_gv", 32'(bus.grant_valid), 32'h1);
    #2;
    rst    = 1'b0;
    mon_en = 1'b0;
    #1;
    check("areset_gv",  32'(bus.grant_valid),   32'h0);
    check("areset_gr",  32'(bus.grant_row),     32'h0);
    check("areset_sel", 32'(bus.select_vector), 32'h0);
    sb.delete();
    model_reset();
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      step(NR'($urandom),
           ($urandom % 3) == 0,
           int'($urandom % NR),
           int'($urandom % NF),
           (($urandom % 4) == 0) ? NF'($urandom) : 4'hF,
           ($urandom % 50) == 0);
    end

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/issue_select.md
# issue_select

Select stage of the scheduler, directly downstream of the wakeup logic. Each cycle it takes the per-row ready/request vector and picks at most one row per functional unit. Selection is round-robin, and it respects each FU's ready signal. It returns registered grants to the FUs and a registered select vector to the wakeup stage so that stage can free issued rows. Rows already granted are masked until the row is reallocated, which closes the window before wakeup drops the request.

## Interface
- NUM_ROWS, 8: scheduler entries (rows); need not be a power of two.
- NUM_FUS, 4: functional units; one grant per FU per cycle.
- ROW_W, $clog2(NUM_ROWS): row index width.
- FU_W, $clog2(NUM_FUS) (minimum 1): FU id width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- request_vector  in  NUM_ROWS  per-row ready request from wakeup.
- alloc_en  in  1  dispatch writes a new entry this cycle.
- alloc_row  in  ROW_W  row being allocated.
- alloc_fu  in  FU_W  FU id the new entry targets.
- fu_ready  in  NUM_FUS  FU f accepts an instruction this cycle.
- flush  in  1  squash: kill in-flight selection and clear issued state.
- grant_valid  out  NUM_FUS  registered; FU f has a grant.
- grant_row  out  NUM_FUS*ROW_W  registered; row granted to FU f, packed with FU0 in the LSBs.
- select_vector  out  NUM_ROWS  registered; one-hot OR of this cycle's grants, to wakeup free path.

## Operation
- State:
  - fu_table[NUM_ROWS] (FU_W each);
  - issued[NUM_ROWS];
  - rr_ptr[NUM_FUS] (ROW_W each);
  - grant registers.
- Allocation: alloc_en writes fu_table[alloc_row] = alloc_fu and clears issued[alloc_row].
- Eligibility of row r for FU f in the current cycle requires all of:
  - request_vector[r];
  - !issued[r];
  - fu_table[r] == f;
  - !(alloc_en && alloc_row == r): allocation wins over a stale request;
  - fu_ready[f];
  - !flush.
- Selection per FU: the first eligible row scanning upward from rr_ptr[f], wrapping at NUM_ROWS-1 to 0.
- Rows partition by fu_table, so grants to different FUs are always to distinct rows.
- On a grant of row r to FU f:
  - issued[r] is set;
  - rr_ptr[f] becomes (r+1) mod NUM_ROWS; at r = NUM_ROWS-1 it wraps to 0.
- No eligible row, or fu_ready[f] low: no grant, and rr_ptr[f] holds.
- Flush, taking effect at the next edge:
  - issued is cleared to all 0;
  - grant_valid and select_vector become 0;
  - no grants are made that cycle;
  - rr_ptr and fu_table hold.
- Flush together with alloc_en: the allocation is still written.
- Reset values:
  - grant_valid = 0, grant_row = 0, select_vector = 0;
  - issued = 0, rr_ptr = 0, fu_table = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Grants resume on the first edge after rst deasserts.

## Timing
- Select latency is one cycle. A request that is eligible in cycle N appears on grant_valid, grant_row and select_vector in cycle N+1, held for exactly one cycle.
- grant_row[f] is 0 whenever grant_valid[f] = 0.
- issued[r] is set at the same edge the grant is registered. A request that stays high in cycle N+1 or later is therefore never granted twice.
- fu_ready is sampled in the selection cycle N. It is not re-checked at N+1, since the FU is committed by asserting ready.
- Allocation in cycle N: row r becomes eligible from cycle N+1 onward, given its request.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then basic grant:
  - Stimulus: hold rst=0 and check all outputs are 0. Release rst. Allocate row 3 to FU1. In the next cycle raise request_vector=8'h08 with fu_ready=4'hF.
  - Required: one cycle later grant_valid=4'b0010, grant_row[FU1]=3, select_vector=8'h08. The following cycle is all zero even though the request is still high.
- Round-robin order:
  - Stimulus: rows 1, 4 and 6 allocated to FU0, with requests held high.
  - Required: successive grants go to rows 1, 4, 6. After reallocation of row 1, its next grant follows row 6, i.e. the pointer wraps 7 to 0 to 1.
- Parallel FUs:
  - Stimulus: rows 0/2/5/7 allocated to FU0/1/2/3, request_vector=8'hA5, fu_ready=4'hF.
  - Required: the same cycle grants grant_valid=4'hF with rows 0, 2, 5, 7, and select_vector=8'hA5.
- Backpressure:
  - Stimulus: fu_ready[2]=0 while row 5 (FU2) requests.
  - Required: no grant and rr_ptr[2] unchanged. Raising fu_ready[2] gives the grant one cycle later.
- Alloc/request collision and flush:
  - Stimulus: alloc_en targets row 4 in the same cycle row 4 requests.
  - Required: no grant for row 4 that cycle, and a grant for row 4 the next cycle if its request stays high.
  - Stimulus: flush while a request is pending.
  - Required: grant_valid=0 in the following cycle and issued cleared.
- Asynchronous reset mid-grant:
  - Stimulus: drop rst between clock edges while grant_valid is nonzero.
  - Required: outputs go to 0 without waiting for a clock edge.
